exposure_sequencer: RTL and testbench

Sequences one UV exposure run. It programs lamp intensity through the shared I2C write controller and waits for the write to finish. It then drives the relay through N on/off cycles with millisecond resolution and reports phase and progress for the 7-segment display. It sits between the front-panel logic (arm/fire/abort, debounced) and the relay pin and i2c_controller.

---
 rtl/exposure_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_exposure_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exposure_sequencer.sv
// UV exposure sequencer: programs lamp intensity over the shared I2C write controller, then
// drives the relay through N on/off cycles with millisecond timing and reports progress.
module exposure_sequencer #(
  parameter int unsigned TICKS_PER_MS   = 16000,
  parameter int unsigned MAX_TIME       = 9999,
  parameter int unsigned MAX_INTENSITY  = 100,
  parameter int unsigned I2C_TIMEOUT_MS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        fire,
  input  logic        abort,
  input  logic [13:0] cfg_on_ms,
  input  logic [13:0] cfg_off_ms,
  input  logic [13:0] cfg_reps,
  input  logic [6:0]  cfg_intensity,
  input  logic        i2c_ready,
  output logic        i2c_enable,
  output logic [7:0]  i2c_data,
  output logic        relay,
  output logic [2:0]  state,
  output logic [13:0] elapsed_ms,
  output logic [13:0] rep_count,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned PW        = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int unsigned TmoCycles = I2C_TIMEOUT_MS * TICKS_PER_MS;
  localparam int unsigned TW        = $clog2(TmoCycles + 1);

  localparam logic [PW-1:0] PrescLast = PW'(TICKS_PER_MS - 1);
  localparam logic [TW-1:0] TmoLast   = TW'(TmoCycles - 1);
  localparam logic [13:0]   MaxTime   = 14'(MAX_TIME);
  localparam logic [6:0]    MaxInt    = 7'(MAX_INTENSITY);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoad    = 3'd1,
    StWaitI2c = 3'd2,
    StArmed   = 3'd3,
    StOn      = 3'd4,
    StOff     = 3'd5,
    StDone    = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [13:0]   elapsed_q, elapsed_d;
  logic [13:0]   rep_q, rep_d;
  logic [13:0]   on_q, on_d;
  logic [13:0]   off_q, off_d;
  logic [13:0]   reps_q, reps_d;
  logic [6:0]    last_written_q, last_written_d;
  logic          seen_low_q, seen_low_d;
  logic          err_q, err_d;
  logic          arm_q;
  logic          relay_q, busy_q, done_q;

  logic [13:0] on_c, off_c, reps_c, rep_inc, phase_len;
  logic [6:0]  int_c;
  logic        presc_wrap, phase_end;

  always_comb begin
    on_c   = (cfg_on_ms > MaxTime) ? MaxTime : cfg_on_ms;
    off_c  = (cfg_off_ms > MaxTime) ? MaxTime : cfg_off_ms;
    reps_c = (cfg_reps == 14'd0) ? 14'd1 : ((cfg_reps > MaxTime) ? MaxTime : cfg_reps);
    int_c  = (cfg_intensity > MaxInt) ? MaxInt : cfg_intensity;
  end

  // ON/OFF are only ever entered with a non-zero length, so phase_len - 1 cannot wrap.
  assign rep_inc    = rep_q + 14'd1;
  assign presc_wrap = (presc_q == PrescLast);
  assign phase_len  = (state_q == StOn) ? on_q : off_q;
  assign phase_end  = presc_wrap && ((elapsed_q + 14'd1) == phase_len);

  always_comb begin
    state_d        = state_q;
    presc_d        = presc_q;
    tmo_d          = tmo_q;
    elapsed_d      = elapsed_q;
    rep_d          = rep_q;
    on_d           = on_q;
    off_d          = off_q;
    reps_d         = reps_q;
    last_written_d = last_written_q;
    seen_low_d     = seen_low_q;
    err_d          = err_q;
    i2c_enable     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arm && !arm_q) begin
          err_d   = 1'b0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (!arm) begin
          state_d = StIdle;
        end else if (i2c_ready) begin
          i2c_enable     = 1'b1;
          last_written_d = int_c;
          seen_low_d     = 1'b0;
          tmo_d          = '0;
          state_d        = StWaitI2c;
        end
      end
      StWaitI2c: begin
        if (!arm) begin
          state_d = StIdle;
        end else if (seen_low_q && i2c_ready) begin
          state_d = StArmed;
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TW'(1);
          if (!i2c_ready) seen_low_d = 1'b1;
        end
      end
      StArmed: begin
        if (!arm) begin
          state_d = StIdle;
        end else if (fire) begin
          on_d      = on_c;
          off_d     = off_c;
          reps_d    = reps_c;
          rep_d     = '0;
          elapsed_d = '0;
          presc_d   = '0;
          if (on_c != 14'd0) begin
            state_d = StOn;
          end else if (off_c != 14'd0) begin
            state_d = StOff;
          end else begin
            rep_d   = reps_c;
            state_d = StDone;
          end
        end else if (int_c != last_written_q) begin
          state_d = StLoad;
        end
      end
      StOn, StOff: begin
        if (!arm) begin
          state_d = StIdle;
        end else if (abort) begin
          state_d = StArmed;
        end else if (phase_end) begin
          presc_d   = '0;
          elapsed_d = '0;
          if ((state_q == StOn) && (off_q != 14'd0)) begin
            state_d = StOff;
          end else begin
            // End of a repetition: either an OFF phase, or an ON phase with no OFF time.
            rep_d = rep_inc;
            if (rep_inc == reps_q)   state_d = StDone;
            else if (on_q == 14'd0)  state_d = StOff;
            else                     state_d = StOn;
          end
        end else if (presc_wrap) begin
          presc_d   = '0;
          elapsed_d = elapsed_q + 14'd1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      StDone: begin
        state_d = arm ? StArmed : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      presc_q        <= '0;
      tmo_q          <= '0;
      elapsed_q      <= '0;
      rep_q          <= '0;
      on_q           <= '0;
      off_q          <= '0;
      reps_q         <= '0;
      last_written_q <= '0;
      seen_low_q     <= 1'b0;
      err_q          <= 1'b0;
      arm_q          <= 1'b0;
      relay_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      tmo_q          <= tmo_d;
      elapsed_q      <= elapsed_d;
      rep_q          <= rep_d;
      on_q           <= on_d;
      off_q          <= off_d;
      reps_q         <= reps_d;
      last_written_q <= last_written_d;
      seen_low_q     <= seen_low_d;
      err_q          <= err_d;
      arm_q          <= arm;
      relay_q        <= (state_d == StOn);
      busy_q         <= (state_d == StOn) || (state_d == StOff);
      done_q         <= (state_d == StDone);
    end
  end

  assign i2c_data   = {1'b0, ((state_q == StLoad) ? int_c : last_written_q)};
  assign relay      = relay_q;
  assign state      = state_q;
  assign elapsed_ms = elapsed_q;
  assign rep_count  = rep_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

  relay_tracks_on: assert property (@(posedge clk) disable iff (rst)
    relay_q == (state_q == StOn));
  done_tracks_state: assert property (@(posedge clk) disable iff (rst)
    done_q == (state_q == StDone));

endmodule

// File: tb/tb_exposure_sequencer.sv
// Bench for exposure_sequencer: a run-schedule model predicts every cycle of a run, plus
// directed checks with hand-computed values and a simple I2C controller responder.
module tb_exposure_sequencer;

  localparam int T    = 4;
  localparam int MAXT = 9999;

  logic        clk, rst, arm, fire, abort, i2c_ready;
  logic [13:0] cfg_on_ms, cfg_off_ms, cfg_reps;
  logic [6:0]  cfg_intensity;
  logic        i2c_enable, relay, busy, done, err;
  logic [7:0]  i2c_data;
  logic [2:0]  state;
  logic [13:0] elapsed_ms, rep_count;

  exposure_sequencer #(
    .TICKS_PER_MS  (T),
    .MAX_TIME      (MAXT),
    .MAX_INTENSITY (100),
    .I2C_TIMEOUT_MS(10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .fire         (fire),
    .abort        (abort),
    .cfg_on_ms    (cfg_on_ms),
    .cfg_off_ms   (cfg_off_ms),
    .cfg_reps     (cfg_reps),
    .cfg_intensity(cfg_intensity),
    .i2c_ready    (i2c_ready),
    .i2c_enable   (i2c_enable),
    .i2c_data     (i2c_data),
    .relay        (relay),
    .state        (state),
    .elapsed_ms   (elapsed_ms),
    .rep_count    (rep_count),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Expected outputs for each cycle after an edge; cnt=0 leaves the counters unchecked.
  typedef struct {
    logic        relay;
    logic [2:0]  st;
    logic [13:0] el;
    logic [13:0] rep;
    logic        dn;
    logic        cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;

  function automatic exp_t mk(input int r, input int s, input int e, input int p, input int d,
                              input int c);
    exp_t x;
    x.relay = r[0];
    x.st    = s[2:0];
    x.el    = e[13:0];
    x.rep   = p[13:0];
    x.dn    = d[0];
    x.cnt   = c[0];
    return x;
  endfunction

  // A run is reps x (on ms high, off ms low), then one DONE cycle, then ARMED.
  task automatic model_fire(input int on, input int off, input int reps);
    int n_on, n_off, n_reps;
    n_on   = (on > MAXT) ? MAXT : on;
    n_off  = (off > MAXT) ? MAXT : off;
    n_reps = (reps == 0) ? 1 : ((reps > MAXT) ? MAXT : reps);
    exp_q.delete();
    for (int r = 0; r < n_reps; r++) begin
      for (int c = 0; c < n_on * T; c++)  exp_q.push_back(mk(1, 4, c / T, r, 0, 1));
      for (int c = 0; c < n_off * T; c++) exp_q.push_back(mk(0, 5, c / T, r, 0, 1));
    end
    exp_q.push_back(mk(0, 6, 0, n_reps, 1, 1));
    exp_q.push_back(mk(0, 3, 0, n_reps, 0, 1));
  endtask

  task automatic model_abort();
    exp_q.delete();
    exp_q.push_back(mk(0, 3, int'(last_exp.el), int'(last_exp.rep), 0, 1));
  endtask

  task automatic model_disarm();
    exp_q.delete();
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
  endtask

  initial begin : compare
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      chk("enable_outside_load", int'(i2c_enable && (state != 3'd1)), 0);
      if (exp_q.size() > 0) begin
        e        = exp_q.pop_front();
        last_exp = e;
        chk("trace_relay", relay, e.relay);
        chk("trace_state", state, e.st);
        chk("trace_done", done, e.dn);
        chk("trace_busy", busy, int'((e.st == 3'd4) || (e.st == 3'd5)));
        if (e.cnt) begin
          chk("trace_elapsed", elapsed_ms, e.el);
          chk("trace_rep", rep_count, e.rep);
        end
      end
    end
  end

  // I2C controller stand-in: drops ready for 5 cycles after each accepted write.
  int         en_count = 0;
  logic [7:0] en_data  = '0;
  logic       i2c_stuck = 1'b0;

  initial begin : responder
    i2c_ready = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      if (i2c_enable) begin
        en_count++;
        en_data = i2c_data;
        if (!i2c_stuck) begin
          @(posedge clk);
          #2;
          i2c_ready = 1'b0;
          repeat (5) @(posedge clk);
          #2;
          i2c_ready = 1'b1;
        end
      end
    end
  end

  task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
    for (int i = 0; i < budget && state != s; i++) @(negedge clk);
    chk(nm, state, s);
  endtask

  task automatic set_cfg(input int on, input int off, input int reps);
    cfg_on_ms  = 14'(on);
    cfg_off_ms = 14'(off);
    cfg_reps   = 14'(reps);
  endtask

  task automatic do_fire(input int on, input int off, input int reps);
    set_cfg(on, off, reps);
    fire = 1'b1;
    model_fire(on, off, reps);
  endtask

  task automatic run_until_done(input int budget, output int cyc, output int hi,
                                output int max_run, output int off_cyc, output int max_el);
    int   run;
    logic seen;
    cyc = 0; hi = 0; max_run = 0; off_cyc = 0; max_el = 0; run = 0; seen = 1'b0;
    while (!seen && cyc < budget) begin
      @(negedge clk);
      fire = 1'b0;
      cyc++;
      if (relay) begin
        hi++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (state == 3'd5) off_cyc++;
      if (state == 3'd4 && int'(elapsed_ms) > max_el) max_el = int'(elapsed_ms);
      if (done) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
  endtask

  int cyc, hi, max_run, off_cyc, max_el, en_before;

  initial begin : stimulus
    rst = 1'b1; arm = 1'b0; fire = 1'b0; abort = 1'b0;
    cfg_intensity = 7'd50;
    set_cfg(3, 2, 2);
    repeat (3) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_relay", relay, 0);
    chk("rst_enable", i2c_enable, 0);
    chk("rst_data", i2c_data, 0);
    chk("rst_elapsed", elapsed_ms, 0);
    chk("rst_rep", rep_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    // Nominal: 3 ms on, 2 ms off, 2 reps -> 12 high, 8 low, 12 high, 8 low, done.
    @(negedge clk);
    arm = 1'b1;
    wait_state(3'd3, 60, "nom_armed");
    chk("nom_en_count", en_count, 1);
    chk("nom_en_data", en_data, 8'h32);
    do_fire(3, 2, 2);
    run_until_done(200, cyc, hi, max_run, off_cyc, max_el);
    chk("nom_latency", cyc, 41);
    chk("nom_relay_hi", hi, 24);
    chk("nom_relay_run", max_run, 12);
    chk("nom_off_cycles", off_cyc, 16);
    @(negedge clk);
    chk("nom_end_state", state, 3);
    chk("nom_end_rep", rep_count, 2);

    // Clamping: intensity 120 -> 100, reps 0 -> 1, on 16000 -> 9999 ms.
    cfg_intensity = 7'd120;
    @(negedge clk);
    wait_state(3'd3, 60, "clamp_armed");
    chk("clamp_en_count", en_count, 2);
    chk("clamp_en_data", en_data, 100);
    do_fire(16000, 1, 0);
    run_until_done(45000, cyc, hi, max_run, off_cyc, max_el);
    chk("clamp_relay_hi", hi, 9999 * 4);
    // elapsed_ms counts completed ms and clears on the wrap that ends the phase.
    chk("clamp_max_elapsed", max_el, 9998);
    chk("clamp_rep", rep_count, 1);
    chk("clamp_latency", cyc, 9999 * 4 + 4 + 1);

    // Zero on time: relay never high, 3 x 8 OFF cycles then done.
    @(negedge clk);
    do_fire(0, 2, 3);
    run_until_done(100, cyc, hi, max_run, off_cyc, max_el);
    chk("zero_on_relay_hi", hi, 0);
    chk("zero_on_off_cycles", off_cyc, 24);
    chk("zero_on_rep", rep_count, 3);

    // Zero on and off: done the cycle after fire, rep_count already at reps.
    @(negedge clk);
    do_fire(0, 0, 5);
    run_until_done(10, cyc, hi, max_run, off_cyc, max_el);
    chk("zero_both_latency", cyc, 1);
    chk("zero_both_rep", rep_count, 5);

    // Abort at elapsed_ms=1 of the first ON phase.
    @(negedge clk);
    @(negedge clk);
    do_fire(3, 2, 2);
    for (int i = 0; i < 20 && !(state == 3'd4 && elapsed_ms == 14'd1); i++) begin
      @(negedge clk);
      fire = 1'b0;
    end
    abort = 1'b1;
    model_abort();
    @(negedge clk);
    abort = 1'b0;
    chk("abort_state", state, 3);
    chk("abort_relay", relay, 0);
    chk("abort_elapsed", elapsed_ms, 1);
    chk("abort_rep", rep_count, 0);

    // Disarm during OFF, then a fire while IDLE is ignored.
    @(negedge clk);
    do_fire(3, 2, 2);
    for (int i = 0; i < 40 && state != 3'd5; i++) begin
      @(negedge clk);
      fire = 1'b0;
    end
    arm = 1'b0;
    model_disarm();
    @(negedge clk);
    chk("disarm_state", state, 0);
    chk("disarm_relay", relay, 0);
    fire = 1'b1;
    @(negedge clk);
    fire = 1'b0;
    @(negedge clk);
    chk("idle_fire_state", state, 0);
    chk("idle_fire_busy", busy, 0);

    // I2C timeout: ready never drops, 40 cycles in WAIT_I2C then err and IDLE.
    i2c_stuck     = 1'b1;
    cfg_intensity = 7'd50;
    arm           = 1'b1;
    wait_state(3'd2, 20, "tmo_wait");
    repeat (39) @(negedge clk);
    chk("tmo_state_39", state, 2);
    chk("tmo_err_39", err, 0);
    @(negedge clk);
    chk("tmo_state_40", state, 0);
    chk("tmo_err_40", err, 1);
    i2c_stuck = 1'b0;
    arm = 1'b0;
    @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    chk("rearm_err", err, 0);
    chk("rearm_state", state, 1);
    wait_state(3'd3, 60, "rearm_armed");

    // Intensity change while ARMED triggers a fresh write.
    en_before     = en_count;
    cfg_intensity = 7'd60;
    @(negedge clk);
    wait_state(3'd3, 60, "reload_armed");
    chk("reload_en_count", en_count, en_before + 1);
    chk("reload_en_data", en_data, 60);

    // Reset during ON returns everything to reset values.
    @(negedge clk);
    do_fire(3, 2, 2);
    for (int i = 0; i < 20 && !(state == 3'd4 && elapsed_ms == 14'd1); i++) begin
      @(negedge clk);
      fire = 1'b0;
    end
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_relay", relay, 0);
    chk("mid_rst_state", state, 0);
    chk("mid_rst_elapsed", elapsed_ms, 0);
    chk("mid_rst_rep", rep_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", i2c_data, 0);
    rst = 1'b0;
    arm = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
